// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: shares the CPU's single Avalon master port between
// instruction fetch and data load/store, one transaction at a time.
// Data accesses get byteenable generation, write-lane replication and
// load extraction/extension; misaligned data requests are rejected
// without a bus cycle.
// Optional feature: define MIPS_BUS_ARB_STATS_EN to add saturating
// transfer/wait counters (stat_fetch, stat_data, stat_wait).
//
// state | meaning
// IDLE  | no transfer; sample and arbitrate requests
// BUS   | Avalon read/write strobe held until waitrequest drops
// DONE  | one-cycle ack to the granted requester

module mips_bus_arbiter #(
    parameter int DATA_PRIO = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifetch_req,
    input  logic [31:0] ifetch_addr,
    output logic        ifetch_ack,
    output logic [31:0] ifetch_data,
    input  logic        dmem_req,
    input  logic        dmem_we,
    input  logic [1:0]  dmem_size,
    input  logic        dmem_signed,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_ack,
    output logic [31:0] dmem_rdata,
    output logic        dmem_misalign,
    output logic        busy,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
`ifdef MIPS_BUS_ARB_STATS_EN
    ,
    output logic [31:0] stat_fetch,
    output logic [31:0] stat_data,
    output logic [31:0] stat_wait
`endif
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t      state, state_nxt;
    logic        pick_data, pick_fetch;
    logic        sel_data;      // current transfer belongs to the data port
    logic        last_data;     // round-robin memory: last grant went to data
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  lane_q;
    logic        misal_in;
    logic [3:0]  be_in;
    logic [31:0] wd_in;
    logic [31:0] lane;
    logic [31:0] load_val;

    // Fetch is always word aligned; the low address bits are deliberately dropped.
    logic unused_fetch_lsb;
    assign unused_fetch_lsb = ^ifetch_addr[1:0];

    // Data request decode: alignment check, byte lanes and replicated store data.
    always_comb begin
        misal_in = 1'b0;
        be_in    = 4'b1111;
        wd_in    = dmem_wdata;
        case (dmem_size)
            2'b00: begin
                be_in = 4'b0001 << dmem_addr[1:0];
                wd_in = {4{dmem_wdata[7:0]}};
            end
            2'b01: begin
                misal_in = dmem_addr[0];
                be_in    = dmem_addr[1] ? 4'b1100 : 4'b0011;
                wd_in    = {2{dmem_wdata[15:0]}};
            end
            2'b10:   misal_in = |dmem_addr[1:0];
            default: misal_in = 1'b1;
        endcase
    end

    // Load extraction: shift the addressed lane down, then extend by size.
    always_comb begin
        lane     = readdata >> {lane_q, 3'b000};
        load_val = lane;
        case (size_q)
            2'b00:   load_val = signed_q ? {{24{lane[7]}}, lane[7:0]}
                                         : {24'h0, lane[7:0]};
            2'b01:   load_val = signed_q ? {{16{lane[15]}}, lane[15:0]}
                                         : {16'h0, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Arbitration, next state and handshake outputs.
    always_comb begin
        state_nxt  = state;
        pick_data  = 1'b0;
        pick_fetch = 1'b0;
        case (state)
            IDLE: begin
                pick_data  = dmem_req && (!ifetch_req || (DATA_PRIO != 0) || !last_data);
                pick_fetch = ifetch_req && !pick_data;
                if (pick_data)       state_nxt = misal_in ? DONE : BUS;
                else if (pick_fetch) state_nxt = BUS;
            end
            BUS:     if (!waitrequest) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign ifetch_ack = (state == DONE) && !sel_data;
    assign dmem_ack   = (state == DONE) && sel_data;

    // Bus pin registers, result capture and round-robin memory.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sel_data      <= 1'b0;
            last_data     <= 1'b0;
            address       <= '0;
            byteenable    <= '0;
            writedata     <= '0;
            read          <= 1'b0;
            write         <= 1'b0;
            size_q        <= '0;
            signed_q      <= 1'b0;
            lane_q        <= '0;
            ifetch_data   <= '0;
            dmem_rdata    <= '0;
            dmem_misalign <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_data) begin
                        sel_data      <= 1'b1;
                        last_data     <= 1'b1;
                        size_q        <= dmem_size;
                        signed_q      <= dmem_signed;
                        lane_q        <= dmem_addr[1:0];
                        dmem_misalign <= misal_in;
                        dmem_rdata    <= '0;
                        if (!misal_in) begin
                            address    <= {dmem_addr[31:2], 2'b00};
                            byteenable <= be_in;
                            writedata  <= wd_in;
                            read       <= !dmem_we;
                            write      <= dmem_we;
                        end
                    end else if (pick_fetch) begin
                        sel_data   <= 1'b0;
                        last_data  <= 1'b0;
                        address    <= {ifetch_addr[31:2], 2'b00};
                        byteenable <= 4'b1111;
                        read       <= 1'b1;
                        write      <= 1'b0;
                    end
                end
                BUS: begin
                    if (!waitrequest) begin
                        read  <= 1'b0;
                        write <= 1'b0;
                        if (!sel_data)  ifetch_data <= readdata;
                        else if (write) dmem_rdata  <= '0;
                        else            dmem_rdata  <= load_val;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MIPS_BUS_ARB_STATS_EN
    // Saturating transfer and wait-cycle counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_fetch <= '0;
            stat_data  <= '0;
            stat_wait  <= '0;
        end else if (state == BUS) begin
            if (waitrequest) begin
                if (stat_wait != 32'hFFFF_FFFF) stat_wait <= stat_wait + 32'd1;
            end else if (sel_data) begin
                if (stat_data != 32'hFFFF_FFFF) stat_data <= stat_data + 32'd1;
            end else begin
                if (stat_fetch != 32'hFFFF_FFFF) stat_fetch <= stat_fetch + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Testbench for mips_bus_arbiter: directed scenarios plus randomized
// transfers checked against a behavioural model of lanes, extension,
// alignment, arbitration and latency.
module tb_mips_bus_arbiter;

    localparam int DATA_PRIO = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ifetch_req = 1'b0, dmem_req = 1'b0;
    logic [31:0] ifetch_addr = '0, dmem_addr = '0, dmem_wdata = '0;
    logic        dmem_we = 1'b0, dmem_signed = 1'b0;
    logic [1:0]  dmem_size = '0;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata = '0;
    logic        ifetch_ack, dmem_ack, dmem_misalign, busy, read, write;
    logic [31:0] ifetch_data, dmem_rdata, address, writedata;
    logic [3:0]  byteenable;
`ifdef MIPS_BUS_ARB_STATS_EN
    logic [31:0] stat_fetch, stat_data, stat_wait;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mips_bus_arbiter #(.DATA_PRIO(DATA_PRIO)) dut (
        .clk(clk), .reset(reset),
        .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr),
        .ifetch_ack(ifetch_ack), .ifetch_data(ifetch_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_size(dmem_size),
        .dmem_signed(dmem_signed), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .dmem_misalign(dmem_misalign),
        .busy(busy), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .waitrequest(waitrequest), .readdata(readdata)
`ifdef MIPS_BUS_ARB_STATS_EN
        , .stat_fetch(stat_fetch), .stat_data(stat_data), .stat_wait(stat_wait)
`endif
    );

    // ---------------- behavioural model ----------------
    int m_last = 1;              // 1 = fetch granted last, 2 = data
    int m_sf = 0, m_sd = 0, m_sw = 0;

    function automatic int m_bytes(logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic logic m_mis(logic [1:0] size, logic [31:0] a);
        if (size == 2'b11) return 1'b1;
        return (a % m_bytes(size)) != 0;
    endfunction

    function automatic logic [3:0] m_be(logic [1:0] size, logic [31:0] a);
        int nb = m_bytes(size);
        int mask = (1 << nb) - 1;
        return 4'(mask << (a % 4));
    endfunction

    function automatic logic [31:0] m_wd(logic [1:0] size, logic [31:0] w);
        logic [31:0] r = '0;
        int nb = m_bytes(size);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(logic [31:0] rd, logic [1:0] size, logic sgn, logic [31:0] a);
        int nb = m_bytes(size);
        logic [31:0] v = rd >> (8 * (a % 4));
        logic [31:0] mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v = v & mask;
        if (sgn && nb < 4 && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    // 0 none, 1 fetch, 2 data; updates the round-robin memory
    function automatic int m_grant(logic fr, logic dr);
        int g = 0;
        if (fr && dr) g = (DATA_PRIO != 0) ? 2 : ((m_last == 1) ? 2 : 1);
        else if (dr)  g = 2;
        else if (fr)  g = 1;
        if (g != 0) m_last = g;
        return g;
    endfunction

    // ---------------- transfer driver / Avalon slave ----------------
    int          r_cyc, r_strobes;
    logic        r_f, r_d, r_mis, r_rd, r_wr, r_unstable, r_both, r_timeout, r_busy_after, r_ack_after;
    logic [31:0] r_idata, r_ddata, r_addr, r_wd;
    logic [3:0]  r_be;

    task automatic run_xfer(input logic fr, input logic dr, input int nwait, input logic [31:0] rd);
        int wcnt = 0;
        r_cyc = 0; r_strobes = 0; r_f = 0; r_d = 0; r_mis = 0; r_rd = 0; r_wr = 0;
        r_unstable = 0; r_both = 0; r_timeout = 0; r_busy_after = 0; r_ack_after = 0;
        r_idata = '0; r_ddata = '0; r_addr = '0; r_wd = '0; r_be = '0;
        ifetch_req = fr; dmem_req = dr;
        for (int c = 0; c < 64; c++) begin
            @(posedge clk); #1;
            r_cyc++;
            if (read && write) r_both = 1;
            if (read || write) begin
                if (r_strobes == 0) begin
                    r_addr = address; r_be = byteenable; r_wd = writedata; r_rd = read; r_wr = write;
                end else if (address !== r_addr || byteenable !== r_be || writedata !== r_wd ||
                             read !== r_rd || write !== r_wr) begin
                    r_unstable = 1;
                end
                r_strobes++;
                waitrequest = (wcnt < nwait);
                wcnt++;
                readdata = rd;
            end else begin
                waitrequest = 1'($urandom);
                readdata = $urandom;
            end
            if (ifetch_ack || dmem_ack) begin
                r_f = ifetch_ack; r_d = dmem_ack; r_mis = dmem_misalign;
                r_idata = ifetch_data; r_ddata = dmem_rdata;
                ifetch_req = 0; dmem_req = 0;
                @(posedge clk); #1;
                r_busy_after = busy; r_ack_after = ifetch_ack | dmem_ack;
                return;
            end
        end
        r_timeout = 1;
        ifetch_req = 0; dmem_req = 0;
    endtask

    task automatic set_data(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [31:0] a, input logic [31:0] w);
        dmem_we = we; dmem_size = size; dmem_signed = sgn; dmem_addr = a; dmem_wdata = w;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 0;
        ifetch_req = 1; dmem_req = 1; waitrequest = 0;
        set_data(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({ifetch_ack, ifetch_data, dmem_ack, dmem_rdata, dmem_misalign, busy,
             address, read, write, writedata, byteenable} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ack=%b/%b busy=%b rd=%b wr=%b addr=%h be=%h required all zero",
                     ifetch_ack, dmem_ack, busy, read, write, address, byteenable);
        end
        ifetch_req = 0; dmem_req = 0;
        reset = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        ifetch_addr = 32'hBFC0_0003;
        void'(m_grant(1'b1, 1'b0)); m_sf++;
        run_xfer(1'b1, 1'b0, 0, 32'h2402_0005);
        vectors++; if (r_timeout !== 1'b0) begin miscompares++; $display("FAIL fetch_timeout: got %b required 0", r_timeout); end
        vectors++; if (r_cyc != 2 || r_f !== 1'b1 || r_d !== 1'b0) begin miscompares++; $display("FAIL fetch_ack: cyc=%0d f=%b d=%b required cyc=2 f=1 d=0", r_cyc, r_f, r_d); end
        vectors++; if (r_strobes != 1 || r_rd !== 1'b1 || r_wr !== 1'b0) begin miscompares++; $display("FAIL fetch_strobe: n=%0d rd=%b wr=%b required 1/1/0", r_strobes, r_rd, r_wr); end
        vectors++; if (r_addr !== 32'hBFC0_0000 || r_be !== 4'hF) begin miscompares++; $display("FAIL fetch_addr: got %h be=%h required bfc00000 be=f", r_addr, r_be); end
        vectors++; if (r_idata !== 32'h2402_0005) begin miscompares++; $display("FAIL fetch_data: got %h required 24020005", r_idata); end
    endtask

    task automatic test_load_extend();
        set_data(1'b0, 2'b00, 1'b1, 32'h0000_1003, '0);
        void'(m_grant(1'b0, 1'b1)); m_sd++;
        run_xfer(1'b0, 1'b1, 0, 32'h80FF_FFFF);
        vectors++; if (r_be !== 4'h8 || r_rd !== 1'b1 || r_addr !== 32'h1000) begin miscompares++; $display("FAIL lb_lanes: be=%h rd=%b addr=%h required be=8 rd=1 addr=1000", r_be, r_rd, r_addr); end
        vectors++; if (r_d !== 1'b1 || r_ddata !== 32'hFFFF_FF80 || r_mis !== 1'b0) begin miscompares++; $display("FAIL lb_signed: ack=%b data=%h mis=%b required 1 ffffff80 0", r_d, r_ddata, r_mis); end
        set_data(1'b0, 2'b00, 1'b0, 32'h0000_1003, '0);
        void'(m_grant(1'b0, 1'b1)); m_sd++;
        run_xfer(1'b0, 1'b1, 0, 32'h80FF_FFFF);
        vectors++; if (r_ddata !== 32'h0000_0080) begin miscompares++; $display("FAIL lbu_zero: got %h required 00000080", r_ddata); end
    endtask

    task automatic test_store_wait();
        set_data(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD);
        void'(m_grant(1'b0, 1'b1)); m_sd++; m_sw += 3;
        run_xfer(1'b0, 1'b1, 3, 32'hFFFF_FFFF);
        vectors++; if (r_strobes != 4 || r_wr !== 1'b1 || r_rd !== 1'b0 || r_unstable !== 1'b0) begin miscompares++; $display("FAIL sh_hold: n=%0d wr=%b rd=%b unstable=%b required 4 1 0 0", r_strobes, r_wr, r_rd, r_unstable); end
        vectors++; if (r_addr !== 32'h2000 || r_be !== 4'hC || r_wd !== 32'hABCD_ABCD) begin miscompares++; $display("FAIL sh_bus: addr=%h be=%h wd=%h required 2000 c abcdabcd", r_addr, r_be, r_wd); end
        vectors++; if (r_cyc != 5 || r_d !== 1'b1 || r_ddata !== 32'h0) begin miscompares++; $display("FAIL sh_ack: cyc=%0d ack=%b data=%h required 5 1 0", r_cyc, r_d, r_ddata); end
    endtask

    task automatic test_misalign();
        set_data(1'b0, 2'b10, 1'b0, 32'h0000_3001, '0);
        void'(m_grant(1'b0, 1'b1));
        run_xfer(1'b0, 1'b1, 0, 32'h1234_5678);
        vectors++; if (r_strobes != 0) begin miscompares++; $display("FAIL lw_mis_nobus: strobes=%0d required 0", r_strobes); end
        vectors++; if (r_cyc != 1 || r_d !== 1'b1 || r_mis !== 1'b1 || r_ddata !== 32'h0) begin miscompares++; $display("FAIL lw_mis_ack: cyc=%0d ack=%b mis=%b data=%h required 1 1 1 0", r_cyc, r_d, r_mis, r_ddata); end
        vectors++; if (r_busy_after !== 1'b0 || r_ack_after !== 1'b0) begin miscompares++; $display("FAIL lw_mis_pulse: busy=%b ack=%b after required 0 0", r_busy_after, r_ack_after); end
    endtask

    task automatic test_arbitration();
        ifetch_addr = 32'h0040_0010;
        set_data(1'b0, 2'b10, 1'b0, 32'h0000_5004, '0);
        for (int i = 0; i < 4; i++) begin
            int g;
            g = m_grant(1'b1, 1'b1);
            if (g == 1) m_sf++; else m_sd++;
            run_xfer(1'b1, 1'b1, 0, 32'h0BAD_F00D + i);
            vectors++;
            if (r_f !== (g == 1) || r_d !== (g == 2) || r_timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL arb_tie[%0d]: f=%b d=%b timeout=%b required grant %0d", i, r_f, r_d, r_timeout, g);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            logic fr, dr;
            int nwait, g;
            logic [31:0] rd, a;
            logic mis;
            fr = 1'($urandom); dr = 1'($urandom);
            if (!fr && !dr) dr = 1;
            nwait = $urandom_range(0, 3);
            rd = $urandom;
            a = $urandom;
            ifetch_addr = $urandom;
            set_data(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
            mis = m_mis(dmem_size, a);
            g = m_grant(fr, dr);
            run_xfer(fr, dr, nwait, rd);
            vectors++;
            if (r_timeout !== 1'b0 || r_f !== (g == 1) || r_d !== (g == 2) || r_both !== 1'b0 ||
                r_unstable !== 1'b0 || r_busy_after !== 1'b0) begin
                miscompares++;
                $display("FAIL rnd_handshake[%0d]: to=%b f=%b d=%b both=%b unst=%b busy=%b required grant %0d", it, r_timeout, r_f, r_d, r_both, r_unstable, r_busy_after, g);
            end
            if (g == 2 && mis) begin
                vectors++;
                if (r_cyc != 1 || r_strobes != 0 || r_mis !== 1'b1 || r_ddata !== 32'h0) begin
                    miscompares++;
                    $display("FAIL rnd_misalign[%0d]: cyc=%0d n=%0d mis=%b data=%h required 1 0 1 0", it, r_cyc, r_strobes, r_mis, r_ddata);
                end
            end else begin
                logic [31:0] ea;
                ea = (g == 1) ? {ifetch_addr[31:2], 2'b00} : {a[31:2], 2'b00};
                if (g == 1) m_sf++; else m_sd++;
                m_sw += nwait;
                vectors++;
                if (r_cyc != nwait + 2 || r_strobes != nwait + 1 || r_addr !== ea) begin
                    miscompares++;
                    $display("FAIL rnd_timing[%0d]: cyc=%0d n=%0d addr=%h required %0d %0d %h", it, r_cyc, r_strobes, r_addr, nwait + 2, nwait + 1, ea);
                end
                if (g == 1) begin
                    vectors++;
                    if (r_be !== 4'hF || r_rd !== 1'b1 || r_wr !== 1'b0 || r_idata !== rd) begin
                        miscompares++;
                        $display("FAIL rnd_fetch[%0d]: be=%h rd=%b wr=%b data=%h required f 1 0 %h", it, r_be, r_rd, r_wr, r_idata, rd);
                    end
                end else begin
                    logic [31:0] ed;
                    ed = dmem_we ? 32'h0 : m_load(rd, dmem_size, dmem_signed, a);
                    vectors++;
                    if (r_be !== m_be(dmem_size, a) || r_rd !== !dmem_we || r_wr !== dmem_we ||
                        (dmem_we && r_wd !== m_wd(dmem_size, dmem_wdata)) || r_mis !== 1'b0 || r_ddata !== ed) begin
                        miscompares++;
                        $display("FAIL rnd_data[%0d]: be=%h rd=%b wr=%b wd=%h mis=%b data=%h required be=%h we=%b wd=%h data=%h",
                                 it, r_be, r_rd, r_wr, r_wd, r_mis, r_ddata, m_be(dmem_size, a), dmem_we,
                                 m_wd(dmem_size, dmem_wdata), ed);
                    end
                end
            end
        end
    endtask

    task automatic test_stats();
`ifdef MIPS_BUS_ARB_STATS_EN
        vectors++;
        if (stat_fetch !== 32'(m_sf) || stat_data !== 32'(m_sd) || stat_wait !== 32'(m_sw)) begin
            miscompares++;
            $display("FAIL stats: got f=%0d d=%0d w=%0d required %0d %0d %0d", stat_fetch, stat_data, stat_wait, m_sf, m_sd, m_sw);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic seen_ack = 0;
        set_data(1'b1, 2'b10, 1'b0, 32'h0000_6000, 32'hCAFE_F00D);
        waitrequest = 1;
        dmem_req = 1;
        @(posedge clk); #1;
        vectors++; if (write !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_start: wr=%b busy=%b required 1 1", write, busy); end
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;
        vectors++; if (read !== 1'b0 || write !== 1'b0 || busy !== 1'b0 || ifetch_ack !== 1'b0 || dmem_ack !== 1'b0) begin miscompares++; $display("FAIL rstmid_drop: rd=%b wr=%b busy=%b ack=%b/%b required all 0", read, write, busy, ifetch_ack, dmem_ack); end
        dmem_req = 0; waitrequest = 0;
        m_last = 1; m_sf = 0; m_sd = 0; m_sw = 0;
        test_stats();
        reset = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ifetch_ack || dmem_ack || read || write) seen_ack = 1;
        end
        vectors++; if (seen_ack !== 1'b0) begin miscompares++; $display("FAIL rstmid_noack: activity=%b required 0", seen_ack); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_load_extend();
        test_store_wait();
        test_misalign();
        test_arbitration();
        test_random();
        test_stats();
        test_reset_mid();
        test_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
